// File: rtl/button_irq_servicer.sv
// button_irq_servicer: Avalon-MM initiator that arms a single-bit edge-capturing
// button PIO and services its interrupt in hardware. Each serviced edge is
// delivered as one event on a valid/ready stream.
// Optional build macro: BUTTON_HOLDOFF_EN adds a debounce hold-off after every
// accepted event, then clears the edge-capture register to drop bounce edges.
module button_irq_servicer #(
   parameter int          READ_LATENCY   = 1,
   parameter logic [15:0] HOLDOFF_CYCLES = 16'd50000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   input  logic        irq,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic        evt_level,
   output logic [7:0]  evt_seq
);

   typedef enum logic [2:0] {ARM, IDLE, RD_CAP, CLR, RD_DAT, EMIT, HOLD, HCLR} state_t;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_CAP  = 2'd3;
   // read hold counter reload: the read is sampled when the counter reaches 0
   localparam logic [1:0] LAT_LOAD  = 2'(READ_LATENCY - 1);

   state_t      state, state_nxt;
   logic [1:0]  lat, lat_nxt;
   logic [1:0]  addr_nxt;
   logic        cs_nxt, wn_nxt;
   logic [31:0] wd_nxt;
   logic        valid_nxt, level_nxt;
   logic [7:0]  seq_nxt;

   // only bit 0 of the responder read data carries information
   logic unused_rd;
   assign unused_rd = &{1'b0, m_readdata[31:1]};

`ifdef BUTTON_HOLDOFF_EN
   logic [15:0] hold_cnt, hold_nxt;
`else
   logic unused_holdoff;
   assign unused_holdoff = &{1'b0, HOLDOFF_CYCLES};
`endif

   // Next-state and next-output decode; bus outputs default to idle every cycle
   always_comb begin
      state_nxt = state;
      lat_nxt   = lat;
      addr_nxt  = ADDR_DATA;
      cs_nxt    = 1'b0;
      wn_nxt    = 1'b1;
      wd_nxt    = 32'h0;
      valid_nxt = evt_valid;
      level_nxt = evt_level;
      seq_nxt   = evt_seq;
`ifdef BUTTON_HOLDOFF_EN
      hold_nxt  = hold_cnt;
`endif
      case (state)
         ARM: begin
            cs_nxt    = 1'b1;
            wn_nxt    = 1'b0;
            addr_nxt  = ADDR_MASK;
            wd_nxt    = 32'h1;
            state_nxt = IDLE;
         end
         IDLE: begin
            if (irq) begin
               cs_nxt    = 1'b1;
               addr_nxt  = ADDR_CAP;
               lat_nxt   = LAT_LOAD;
               state_nxt = RD_CAP;
            end
         end
         RD_CAP: begin
            if (lat != 2'd0) begin
               cs_nxt   = 1'b1;
               addr_nxt = ADDR_CAP;
               lat_nxt  = lat - 2'd1;
            end else if (m_readdata[0]) begin
               cs_nxt    = 1'b1;
               wn_nxt    = 1'b0;
               addr_nxt  = ADDR_CAP;
               state_nxt = CLR;
            end else begin
               state_nxt = IDLE;   // spurious irq: nothing captured
            end
         end
         CLR: begin
            cs_nxt    = 1'b1;
            addr_nxt  = ADDR_DATA;
            lat_nxt   = LAT_LOAD;
            state_nxt = RD_DAT;
         end
         RD_DAT: begin
            if (lat != 2'd0) begin
               cs_nxt   = 1'b1;
               addr_nxt = ADDR_DATA;
               lat_nxt  = lat - 2'd1;
            end else begin
               level_nxt = m_readdata[0];
               valid_nxt = 1'b1;
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (evt_ready) begin
               valid_nxt = 1'b0;
               seq_nxt   = evt_seq + 8'd1;
`ifdef BUTTON_HOLDOFF_EN
               if (HOLDOFF_CYCLES <= 16'd1) begin
                  cs_nxt    = 1'b1;
                  wn_nxt    = 1'b0;
                  addr_nxt  = ADDR_CAP;
                  state_nxt = HCLR;
               end else begin
                  hold_nxt  = HOLDOFF_CYCLES;
                  state_nxt = HOLD;
               end
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef BUTTON_HOLDOFF_EN
         // counter includes the clear-write cycle, so the write is issued at 2
         HOLD: begin
            if (hold_cnt <= 16'd2) begin
               cs_nxt    = 1'b1;
               wn_nxt    = 1'b0;
               addr_nxt  = ADDR_CAP;
               state_nxt = HCLR;
            end else begin
               hold_nxt = hold_cnt - 16'd1;
            end
         end
         // clear-write cycle; irq still reflects the bounce edges here
         HCLR: state_nxt = IDLE;
`endif
         default: state_nxt = ARM;
      endcase
   end

   // State and registered outputs; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ARM;
         lat          <= 2'd0;
         m_address    <= 2'd0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= 32'h0;
         evt_valid    <= 1'b0;
         evt_level    <= 1'b0;
         evt_seq      <= 8'd0;
`ifdef BUTTON_HOLDOFF_EN
         hold_cnt     <= 16'd0;
`endif
      end else begin
         state        <= state_nxt;
         lat          <= lat_nxt;
         m_address    <= addr_nxt;
         m_chipselect <= cs_nxt;
         m_write_n    <= wn_nxt;
         m_writedata  <= wd_nxt;
         evt_valid    <= valid_nxt;
         evt_level    <= level_nxt;
         evt_seq      <= seq_nxt;
`ifdef BUTTON_HOLDOFF_EN
         hold_cnt     <= hold_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_button_irq_servicer.sv
// Directed bench for button_irq_servicer with a behavioural button PIO model.
module tb_button_irq_servicer;

`ifdef BUTTON_HOLDOFF_EN
   localparam int HOLD_EN = 1;
`else
   localparam int HOLD_EN = 0;
`endif

   localparam logic [7:0] W2 = 8'h21, R3 = 8'h70, W3 = 8'h30, R0 = 8'h40;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  m_address;
   logic        m_chipselect, m_write_n;
   logic [31:0] m_writedata, m_readdata;
   logic        irq;
   logic        evt_valid, evt_level;
   logic        evt_ready = 1'b0;
   logic [7:0]  evt_seq;

   // responder model state
   logic cap = 1'b0, mask = 1'b0, pin = 1'b0;
   logic edge_set = 1'b0, spur = 1'b0;

   int total = 0, bad = 0, cyc = 0;
   logic [7:0] bus_q[$];
   int         bus_t[$];
   logic [8:0] ev_q[$];
   int vld_cycles = 0, irq_rise = 0, vld_rise = 0, acc_cyc = 0;
   logic irq_d = 1'b0, vld_d = 1'b0;

   button_irq_servicer #(.READ_LATENCY(1), .HOLDOFF_CYCLES(16'd10)) dut (
      .clk(clk), .reset(reset), .m_address(m_address), .m_chipselect(m_chipselect),
      .m_write_n(m_write_n), .m_writedata(m_writedata), .m_readdata(m_readdata),
      .irq(irq), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_level(evt_level), .evt_seq(evt_seq));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // button PIO: any write to addr 3 clears capture, a new edge wins
   always @(posedge clk) begin
      if (m_chipselect && !m_write_n && m_address == 2'd2) mask <= m_writedata[0];
      if (m_chipselect && !m_write_n && m_address == 2'd3) cap <= 1'b0;
      if (edge_set) cap <= 1'b1;
   end
   assign irq = (cap & mask) | spur;

   always_comb begin
      m_readdata = 32'h0;
      if (m_chipselect && m_write_n)
         case (m_address)
            2'd0: m_readdata = {31'h0, pin};
            2'd2: m_readdata = {31'h0, mask};
            2'd3: m_readdata = {31'h0, cap};
            default: m_readdata = 32'h0;
         endcase
   end

   // monitor: bus log, accepted events, edge timestamps
   always @(negedge clk) begin
      if (m_chipselect) begin
         bus_q.push_back({1'b0, m_write_n, m_address, m_writedata[3:0]});
         bus_t.push_back(cyc);
      end
      if (evt_valid && evt_ready) begin
         ev_q.push_back({evt_level, evt_seq});
         acc_cyc = cyc;
      end
      if (evt_valid) vld_cycles++;
      if (irq && !irq_d) irq_rise = cyc;
      if (evt_valid && !vld_d) vld_rise = cyc;
      irq_d = irq;
      vld_d = evt_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_edge();
      edge_set = 1'b1;
      tick(1);
      edge_set = 1'b0;
   endtask

   // one full serviced edge with the consumer always ready
   task automatic do_event(input logic lvl);
      int n;
      pin = lvl;
      evt_ready = 1'b1;
      n = ev_q.size();
      pulse_edge();
      for (int k = 0; k < 40 && ev_q.size() == n; k++) tick(1);
      chk("evt_timeout", 32'(ev_q.size() > n), 32'd1);
      tick(12);
   endtask

   initial begin
      int n, unstable, found, a;
      logic [7:0] seq0;

      // reset state
      tick(3);
      @(negedge clk);
      chk("rst_cs", m_chipselect, 0);
      chk("rst_wn", m_write_n, 1);
      chk("rst_addr", m_address, 0);
      chk("rst_wd", m_writedata, 0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_level", evt_level, 0);
      chk("rst_seq", evt_seq, 0);

      // first cycle after release writes the mask
      @(posedge clk); #1;
      reset = 1'b0;
      bus_q.delete(); bus_t.delete();
      @(posedge clk);
      @(negedge clk);
      chk("arm_cs", m_chipselect, 1);
      chk("arm_code", {1'b0, m_write_n, m_address, m_writedata[3:0]}, W2);
      chk("arm_wd", m_writedata, 32'h1);
      tick(5);
      chk("arm_buslen", bus_q.size(), 1);
      chk("arm_valid", evt_valid, 0);
      chk("arm_seq", evt_seq, 0);

      // normal event, level 0
      bus_q.delete(); vld_cycles = 0;
      do_event(1'b0);
      chk("ev0_buslen", bus_q.size(), 32'(3 + HOLD_EN));
      chk("ev0_bus0", bus_q[0], R3);
      chk("ev0_bus1", bus_q[1], W3);
      chk("ev0_bus2", bus_q[2], R0);
      chk("ev0_count", ev_q.size(), 1);
      chk("ev0_lvlseq", ev_q[0], {1'b0, 8'd0});
      chk("ev0_seq", evt_seq, 1);
      chk("ev0_pulse", vld_cycles, 1);
      chk("ev0_latency", vld_rise - irq_rise, 4);

      // normal event, level 1
      do_event(1'b1);
      chk("ev1_lvlseq", ev_q[1], {1'b1, 8'd1});
      chk("ev1_seq", evt_seq, 2);

      // spurious irq: single capture read, no clear, no event
      bus_q.delete();
      n = ev_q.size();
      spur = 1'b1;
      tick(1);
      spur = 1'b0;
      tick(8);
      chk("spur_buslen", bus_q.size(), 1);
      chk("spur_bus0", bus_q[0], R3);
      chk("spur_noev", ev_q.size(), n);
      chk("spur_valid", evt_valid, 0);

      // consumer stall with three more edges
      pin = 1'b1;
      evt_ready = 1'b0;
      n = ev_q.size();
      seq0 = evt_seq;
      pulse_edge();
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         @(negedge clk);
         if (evt_valid) found = 1;
      end
      chk("stall_valid_seen", found, 1);
      chk("stall_level", evt_level, 1);
      @(posedge clk); #1;
      pin = 1'b0;
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         edge_set = (i == 3 || i == 8 || i == 13);
         @(negedge clk);
         if (!evt_valid || evt_level !== 1'b1) unstable++;
         @(posedge clk); #1;
      end
      edge_set = 1'b0;
      chk("stall_stable", unstable, 0);
      evt_ready = 1'b1;
      tick(30);
      chk("stall_evcount", ev_q.size() - n, 32'(2 - HOLD_EN));
      chk("stall_ev0", ev_q[n], {1'b1, seq0});
`ifndef BUTTON_HOLDOFF_EN
      chk("stall_ev1", ev_q[n+1], {1'b0, seq0 + 8'd1});
`endif
      chk("stall_seq", evt_seq, 32'(8'(seq0 + 8'(2 - HOLD_EN))));

      // sequence wrap
      for (int k = 0; k < 300 && evt_seq != 8'd255; k++) do_event(k[0]);
      chk("wrap_255", evt_seq, 255);
      do_event(1'b1);
      chk("wrap_0", evt_seq, 0);
      chk("wrap_last", ev_q[ev_q.size()-1], {1'b1, 8'd255});

      // reset in the middle of the data read
      evt_ready = 1'b1;
      pin = 1'b1;
      pulse_edge();
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         @(negedge clk);
         if (m_chipselect && m_write_n && m_address == 2'd0) found = 1;
      end
      chk("rdat_seen", found, 1);
      reset = 1'b1;
      n = ev_q.size();
      @(negedge clk);
      chk("mid_rst_cs", m_chipselect, 0);
      chk("mid_rst_wn", m_write_n, 1);
      chk("mid_rst_valid", evt_valid, 0);
      chk("mid_rst_seq", evt_seq, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rearm_code", {1'b0, m_write_n, m_chipselect, m_address, m_writedata[3:0]},
          {1'b0, 1'b0, 1'b1, 2'd2, 4'd1});
      tick(6);
      chk("rearm_noev", ev_q.size(), n);
      chk("rearm_valid", evt_valid, 0);

`ifdef BUTTON_HOLDOFF_EN
      // hold-off: bounce edges discarded by the clear at cycle 10
      evt_ready = 1'b1;
      pin = 1'b1;
      bus_q.delete(); bus_t.delete();
      n = ev_q.size();
      pulse_edge();
      for (int k = 0; k < 40 && ev_q.size() == n; k++) tick(1);
      chk("hold_accept", ev_q.size(), n + 1);
      a = acc_cyc;
      tick(1);
      pulse_edge();
      tick(3);
      pulse_edge();
      tick(15);
      chk("hold_noev", ev_q.size(), n + 1);
      chk("hold_valid", evt_valid, 0);
      chk("hold_buslen", bus_q.size(), 4);
      chk("hold_clr", bus_q[3], W3);
      chk("hold_clr_cyc", bus_t[3] - a, 10);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
